decoder_seq_nto2n: RTL and testbench
====================================

// Module: decoder_seq_nto2n
// PURPOSE
//  Parametrised, registered N-to-2^N one-hot decoder with a valid/ready input handshake.
//  Adds an auto-scan mode that walks the one-hot output through all 2^N positions.
//  Successor to the fixed-width combinational decoders; drives row/column selects,
//  LED scan lines and chip-select fan-out.
// PARAMETERS
//  N_IN   4  select width; OUT_W = 2**N_IN (localparam, not overridable)
//  DWELL  4  clock cycles each scan position is held (>=1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  en         in   1      block enable; low aborts any operation
//  in_valid   in   1      select word valid
//  in_ready   out  1      block can accept a select word
//  in         in   N_IN   select index (decode target / scan start index)
//  mode       in   1      0 = decode, 1 = scan; sampled with the select word
//  out        out  OUT_W  registered one-hot output, or all-zero
//  out_valid  out  1      out holds a live one-hot value
//  busy       out  1      scan in progress
//  scan_wrap  out  1      one-cycle pulse when the scan index wraps OUT_W-1 -> 0
// BEHAVIOUR
//  - Reset values: out=0, out_valid=0, busy=0, scan_wrap=0, state=IDLE.
//  - in_ready = en && (state != SCAN). Combinational. Equals 1 one cycle after reset when en=1.
//  - Accept = in_valid && in_ready on a clk edge.
//  - FSM states:
//    - IDLE: out=0.
//    - HOLD: decoded value is held.
//    - SCAN: walking the output.
//  - Accept with mode=0 (from IDLE or HOLD): out <= 1<<in on the next edge,
//    so latency is 1 cycle. out_valid <= 1. Go to HOLD.
//    A new accept in HOLD replaces out directly, with no zero cycle in between.
//  - Accept with mode=1: out <= 1<<in, out_valid <= 1, busy <= 1. Go to SCAN.
//    A dwell counter is loaded with DWELL-1.
//  - In SCAN, every DWELL cycles the index advances by 1, modulo OUT_W.
//    - On the step from OUT_W-1 to 0, scan_wrap=1 for exactly that cycle.
//    - After OUT_W positions (the full circle back to the start index), the next edge
//      gives out=0, out_valid=0, busy=0, state=IDLE.
//    - Total SCAN duration = OUT_W*DWELL cycles from the first registered output.
//  - in_valid during SCAN is ignored: in_ready=0 and nothing is queued.
//  - en low (sampled on the edge) in any state: next edge out=0, out_valid=0, busy=0,
//    scan_wrap=0, state=IDLE. Has priority over an accept in the same cycle.
//  - rst has priority over everything. Reset mid-scan clears the block in one cycle
//    with no wrap pulse.
//  - Start index = OUT_W-1: the first step wraps, so scan_wrap fires DWELL cycles
//    after scan start. Start index 0: scan_wrap fires on the final step, then IDLE.
//  - DWELL=1: the index advances every cycle.
// CONFIGURATION
//  - DECODER_SCAN_EN defined: scan mode is implemented as above.
//  - Not defined:
//    - mode is ignored and every accept is a decode.
//    - SCAN state and dwell counter are removed; busy and scan_wrap are tied to 0.
//    - in_ready = en.
// STRUCTURE
//  - decoder_pkg:
//    - FSM state encodings ST_IDLE, ST_HOLD, ST_SCAN.
//    - Function onehot(idx, width).
//    - MODE_DECODE / MODE_SCAN constants.
//  - Sub-module decoder_dwell_timer:
//    - Parametrised down-counter (width = clog2(DWELL)).
//    - Ports: load, tick (terminal-count pulse).
//    - Instantiated only under DECODER_SCAN_EN.
//  - Top holds the FSM, the index register and the output register.
// TESTING  (N_IN=4, DWELL=2 unless noted)
//  1. Reset, then en=1: out=16'h0000, out_valid=0, in_ready=1.
//     Decode 4'b0000..4'b1111 in back-to-back cycles: each out = 1<<in one cycle
//     later, with no gaps.
//  2. Decode in=5, then en=0 for one cycle: out=16'h0020 then 16'h0000, out_valid
//     falls, and a same-cycle accept is ignored.
//  3. Scan from in=14:
//     - out = 0x4000, 0x8000, 0x0001, ... for 2 cycles each.
//     - scan_wrap pulses once, on the 0x8000->0x0001 step.
//     - After 32 cycles: out=0, busy=0.
//  4. in_valid=1 with in=3 held during a scan: in_ready=0 throughout and the scan
//     sequence is unchanged. After busy falls, the word is accepted -> out=0x0008.
//  5. rst=1 mid-scan at position 9: next edge all outputs at reset values, no
//     scan_wrap pulse.
//  6. DECODER_SCAN_EN undefined: mode=1, in=2 -> out=0x0004 held (HOLD);
//     busy and scan_wrap stay 0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequential N-to-2^N decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest decode the helper supports (N_IN up to 8).
  localparam int unsigned MAX_IDX_W = 8;
  localparam int unsigned MAX_OUT_W = 256;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_IDX_W-1:0] idx,
                                                  input int unsigned width);
    onehot = '0;
    if (32'(idx) < width) onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/decoder_dwell_timer.sv
// Dwell down-counter for the scan walk: tick marks the last cycle of a position,
// after which the count reloads itself.
module decoder_dwell_timer #(
  parameter  int unsigned DWELL = 4,
  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tick
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= RELOAD;
    end else if (load || (r_cnt == '0)) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign tick = (r_cnt == '0);

endmodule

// File: rtl/decoder_seq_nto2n.sv
// Registered N-to-2^N one-hot decoder with valid/ready input handshake.
// Auto-scan mode (walk the one-hot through all positions) exists only when DECODER_SCAN_EN is defined.
module decoder_seq_nto2n
  import decoder_pkg::*;
#(
  parameter  int unsigned N_IN  = 4,
  parameter  int unsigned DWELL = 4,
  localparam int unsigned OUT_W = 2**N_IN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in,
  input  logic             mode,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             busy,
  output logic             scan_wrap
);

  state_t           r_state, w_state_nxt;
  logic [OUT_W-1:0] r_out, w_out_nxt, w_onehot_in;
  logic             r_out_valid, w_out_valid_nxt;
  logic             w_accept;

  assign w_onehot_in = OUT_W'(onehot(MAX_IDX_W'(in), OUT_W));
  assign w_accept    = in_valid && in_ready;

`ifdef DECODER_SCAN_EN
  logic [N_IN-1:0]  r_idx, r_start, w_idx_nxt, w_start_nxt, w_idx_step;
  logic [OUT_W-1:0] w_onehot_step;
  logic             r_busy, w_busy_nxt, r_scan_wrap, w_wrap_nxt;
  logic             w_load, w_tick;

  assign w_idx_step    = r_idx + N_IN'(1);
  assign w_onehot_step = OUT_W'(onehot(MAX_IDX_W'(w_idx_step), OUT_W));
  assign in_ready      = en && (r_state != ST_SCAN);
  assign busy          = r_busy;
  assign scan_wrap     = r_scan_wrap;

  decoder_dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .tick (w_tick)
  );
`else
  logic w_unused_cfg;

  assign w_unused_cfg = mode ^ (DWELL == 0);
  assign in_ready     = en;
  assign busy         = 1'b0;
  assign scan_wrap    = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_out_nxt       = r_out;
    w_out_valid_nxt = r_out_valid;
`ifdef DECODER_SCAN_EN
    w_idx_nxt       = r_idx;
    w_start_nxt     = r_start;
    w_busy_nxt      = r_busy;
    w_wrap_nxt      = 1'b0;
    w_load          = 1'b0;
`endif
    if (!en) begin
      w_state_nxt     = ST_IDLE;
      w_out_nxt       = '0;
      w_out_valid_nxt = 1'b0;
`ifdef DECODER_SCAN_EN
      w_busy_nxt      = 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (w_accept) begin
            w_out_nxt       = w_onehot_in;
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = ST_HOLD;
`ifdef DECODER_SCAN_EN
            w_idx_nxt       = in;
            w_start_nxt     = in;
            if (mode == MODE_SCAN) begin
              w_state_nxt = ST_SCAN;
              w_busy_nxt  = 1'b1;
              w_load      = 1'b1;
            end
`endif
          end
        end
`ifdef DECODER_SCAN_EN
        // Stepping back onto the start index ends the walk instead of showing it again.
        ST_SCAN: begin
          if (w_tick) begin
            w_wrap_nxt = (r_idx == '1);
            if (w_idx_step == r_start) begin
              w_state_nxt     = ST_IDLE;
              w_out_nxt       = '0;
              w_out_valid_nxt = 1'b0;
              w_busy_nxt      = 1'b0;
            end else begin
              w_idx_nxt = w_idx_step;
              w_out_nxt = w_onehot_step;
            end
          end
        end
`endif
        default: begin
          w_state_nxt     = ST_IDLE;
          w_out_nxt       = '0;
          w_out_valid_nxt = 1'b0;
`ifdef DECODER_SCAN_EN
          w_busy_nxt      = 1'b0;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_out       <= '0;
      r_out_valid <= 1'b0;
`ifdef DECODER_SCAN_EN
      r_busy      <= 1'b0;
      r_scan_wrap <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= w_out_valid_nxt;
`ifdef DECODER_SCAN_EN
      r_busy      <= w_busy_nxt;
      r_scan_wrap <= w_wrap_nxt;
`endif
    end
  end

`ifdef DECODER_SCAN_EN
  always_ff @(posedge clk) begin
    r_idx   <= w_idx_nxt;
    r_start <= w_start_nxt;
  end
`endif

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_decoder_seq_nto2n.sv
// Self-checking bench for decoder_seq_nto2n (N_IN=4, DWELL=2): cycle model plus directed literal checks.
module tb_decoder_seq_nto2n;

  localparam int N_IN  = 4;
  localparam int DWELL = 2;
  localparam int OUT_W = 16;
`ifdef DECODER_SCAN_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, en, in_valid, mode;
  logic [N_IN-1:0]   in_w;
  logic              in_ready, out_valid, busy, scan_wrap;
  logic [OUT_W-1:0]  out_w;

  always #5 clk = ~clk;

  decoder_seq_nto2n #(.N_IN(N_IN), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_w),
    .mode      (mode),
    .out       (out_w),
    .out_valid (out_valid),
    .busy      (busy),
    .scan_wrap (scan_wrap)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a scan is described by its start index and elapsed cycles only.
  logic [OUT_W-1:0] m_out;
  logic             m_vld, m_busy, m_wrap, m_scan;
  int               m_t, m_start;

  function automatic int pos_at(input int s, input int t);
    return (s + t / DWELL) % OUT_W;
  endfunction

  function automatic bit wrap_at(input int s, input int t);
    return (t > 0) && (t % DWELL == 0) && (pos_at(s, t) == 0);
  endfunction

  always @(posedge clk) begin
    if (rst || !en) begin
      m_scan <= 1'b0; m_out <= '0; m_vld <= 1'b0; m_busy <= 1'b0; m_wrap <= 1'b0;
    end else if (m_scan) begin
      m_t    <= m_t + 1;
      m_wrap <= wrap_at(m_start, m_t + 1);
      if (m_t + 1 == OUT_W * DWELL) begin
        m_scan <= 1'b0; m_out <= '0; m_vld <= 1'b0; m_busy <= 1'b0;
      end else begin
        m_out <= 16'(1) << pos_at(m_start, m_t + 1);
      end
    end else if (in_valid) begin
      m_wrap <= 1'b0;
      m_out  <= 16'(1) << in_w;
      m_vld  <= 1'b1;
      if (SCAN && mode) begin
        m_scan <= 1'b1; m_busy <= 1'b1; m_t <= 0; m_start <= int'(in_w);
      end
    end else begin
      m_wrap <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_out", 32'(out_w), 32'(m_out));
      chk("model_out_valid", 32'(out_valid), 32'(m_vld));
      chk("model_busy", 32'(busy), 32'(m_busy));
      chk("model_scan_wrap", 32'(scan_wrap), 32'(m_wrap));
      chk("model_in_ready", 32'(in_ready), 32'(en && !m_scan));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, wraps;
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; mode = 1'b0; in_w = '0;
    cyc(); cyc();
    chk_on = 1'b1;
    chk("reset_out", 32'(out_w), 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_scan_wrap", 32'(scan_wrap), 32'h0);
    rst = 1'b0; en = 1'b1;
    cyc();
    chk("ready_after_reset", 32'(in_ready), 32'h1);

    // Back-to-back decodes of every index.
    for (int i = 0; i < OUT_W; i++) begin
      in_w = 4'(i); mode = 1'b0; in_valid = 1'b1;
      cyc();
      chk("decode_out", 32'(out_w), 32'(16'(1) << i));
      chk("decode_valid", 32'(out_valid), 32'h1);
    end

    // Decode 5, then en low with a simultaneous request.
    in_w = 4'd5; cyc();
    chk("decode5", 32'(out_w), 32'h0020);
    en = 1'b0; in_w = 4'd9;
    cyc();
    chk("en_low_out", 32'(out_w), 32'h0);
    chk("en_low_valid", 32'(out_valid), 32'h0);
    en = 1'b1; in_valid = 1'b0;
    cyc();
    chk("en_low_no_accept", 32'(out_w), 32'h0);

`ifdef DECODER_SCAN_EN
    // Scan from 14: wraps once on 0x8000 -> 0x0001, lasts 32 cycles.
    in_w = 4'd14; mode = 1'b1; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0; mode = 1'b0;
    chk("scan14_first", 32'(out_w), 32'h4000);
    chk("scan14_busy", 32'(busy), 32'h1);
    n = 0; wraps = 0;
    while (busy && n < 100) begin
      cyc(); n++;
      if (scan_wrap) wraps++;
      if (n == 1) chk("scan14_dwell", 32'(out_w), 32'h4000);
      if (n == 2) chk("scan14_step1", 32'(out_w), 32'h8000);
      if (n == 4) begin
        chk("scan14_step2", 32'(out_w), 32'h0001);
        chk("scan14_wrap", 32'(scan_wrap), 32'h1);
      end
    end
    chk("scan14_len", 32'(n), 32'd32);
    chk("scan14_wraps", 32'(wraps), 32'd1);
    chk("scan14_end_out", 32'(out_w), 32'h0);

    // Scan from 0 with a request held throughout; wrap lands on the final step.
    in_w = 4'd0; mode = 1'b1; in_valid = 1'b1;
    cyc();
    in_w = 4'd3; mode = 1'b0;
    n = 0; wraps = 0;
    while (busy && n < 100) begin
      chk("scan0_not_ready", 32'(in_ready), 32'h0);
      cyc(); n++;
      if (scan_wrap) wraps++;
    end
    chk("scan0_len", 32'(n), 32'd32);
    chk("scan0_final_wrap", 32'(scan_wrap), 32'h1);
    chk("scan0_wraps", 32'(wraps), 32'd1);
    cyc();
    chk("held_word_accepted", 32'(out_w), 32'h0008);
    in_valid = 1'b0;

    // Scan from 15: first step wraps after DWELL cycles.
    in_w = 4'd15; mode = 1'b1; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0; mode = 1'b0;
    cyc(); cyc();
    chk("scan15_wrap", 32'(scan_wrap), 32'h1);
    chk("scan15_out", 32'(out_w), 32'h0001);
    en = 1'b0;
    cyc();
    chk("scan_abort_busy", 32'(busy), 32'h0);
    chk("scan_abort_out", 32'(out_w), 32'h0);
    en = 1'b1;
    cyc();

    // Reset at position 9.
    in_w = 4'd7; mode = 1'b1; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0; mode = 1'b0;
    repeat (4) cyc();
    chk("scan7_pos9", 32'(out_w), 32'h0200);
    rst = 1'b1;
    cyc();
    chk("midscan_rst_out", 32'(out_w), 32'h0);
    chk("midscan_rst_busy", 32'(busy), 32'h0);
    chk("midscan_rst_wrap", 32'(scan_wrap), 32'h0);
    chk("midscan_rst_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;
    cyc();
`else
    // Without scan support, mode is ignored and the value is held.
    in_w = 4'd2; mode = 1'b1; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("noscan_out", 32'(out_w), 32'h0004);
    repeat (5) cyc();
    chk("noscan_hold", 32'(out_w), 32'h0004);
    chk("noscan_busy", 32'(busy), 32'h0);
    chk("noscan_wrap", 32'(scan_wrap), 32'h0);
    chk("noscan_ready", 32'(in_ready), 32'h1);
    in_w = 4'd7; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0; mode = 1'b0;
    chk("noscan_replace", 32'(out_w), 32'h0080);
    rst = 1'b1;
    cyc();
    chk("noscan_rst_out", 32'(out_w), 32'h0);
    rst = 1'b0;
    cyc();
`endif

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
